// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: derives PC/FD/DE controls from Tuse/Tnew and MDU busy state.
// Latency: hazard outputs are combinational (zero cycles); md_cnt and stall_cnt are registered.
// Backpressure: stall freezes PC and FD_REG and bubbles DE_REG; Req (flush) overrides stall.
module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_clear,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] md_cnt;
    logic             hz_rs;
    logic             hz_rt;
    logic             hz_md;

    // tuse=3 never stalls since no 2-bit tnew can exceed it
    assign hz_rs = (D_rs_addr != 5'd0) &&
                   (((E_wa == D_rs_addr) && (E_tnew > D_rs_tuse)) ||
                    ((M_wa == D_rs_addr) && (M_tnew > D_rs_tuse)));
    assign hz_rt = (D_rt_addr != 5'd0) &&
                   (((E_wa == D_rt_addr) && (E_tnew > D_rt_tuse)) ||
                    ((M_wa == D_rt_addr) && (M_tnew > D_rt_tuse)));

    assign md_busy = (md_cnt != '0);
    assign hz_md   = D_is_md && (md_busy || E_md_start);

    // Flush wins: the pipeline registers clear themselves on Req, so no stall then
    assign stall    = ~reset & ~Req & (hz_rs | hz_rt | hz_md);
    assign PC_en    = ~stall;
    assign FD_en    = ~stall;
    assign DE_clear = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            // A start being flushed by Req is dropped; a running op keeps counting
            if (E_md_start && !Req) begin
                md_cnt <= E_md_div ? DIV_LOAD : MULT_LOAD;
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - 1'b1;
            end
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: vector table for the hazard logic plus MDU/reset/flush sequences.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_div;
    logic        stall, PC_en, FD_en, DE_clear, md_busy;
    logic [31:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset), .Req(Req),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_is_md(D_is_md),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .stall(stall), .PC_en(PC_en), .FD_en(FD_en), .DE_clear(DE_clear),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0] rs;  logic [1:0] rs_tu;
        logic [4:0] rt;  logic [1:0] rt_tu;
        logic [4:0] ewa; logic [1:0] etn;
        logic [4:0] mwa; logic [1:0] mtn;
        logic       md;
        logic       req;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [4:0] rs, input logic [1:0] rs_tu,
                                input logic [4:0] rt, input logic [1:0] rt_tu,
                                input logic [4:0] ewa, input logic [1:0] etn,
                                input logic [4:0] mwa, input logic [1:0] mtn,
                                input logic md, input logic req, input logic exp_stall);
        vec_t v;
        v.rs = rs; v.rs_tu = rs_tu; v.rt = rt; v.rt_tu = rt_tu;
        v.ewa = ewa; v.etn = etn; v.mwa = mwa; v.mtn = mtn;
        v.md = md; v.req = req; v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ctrl(input string nm, input logic exp_stall);
        chk({nm, ".stall"},    {31'd0, stall},    {31'd0, exp_stall});
        chk({nm, ".PC_en"},    {31'd0, PC_en},    {31'd0, ~exp_stall});
        chk({nm, ".FD_en"},    {31'd0, FD_en},    {31'd0, ~exp_stall});
        chk({nm, ".DE_clear"}, {31'd0, DE_clear}, {31'd0, exp_stall});
    endtask

    task automatic set_idle();
        Req = 0; D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
        D_is_md = 0; E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
        E_md_start = 0; E_md_div = 0;
    endtask

    task automatic apply(input vec_t v);
        D_rs_addr = v.rs; D_rs_tuse = v.rs_tu; D_rt_addr = v.rt; D_rt_tuse = v.rt_tu;
        E_wa = v.ewa; E_tnew = v.etn; M_wa = v.mwa; M_tnew = v.mtn;
        D_is_md = v.md; Req = v.req; E_md_start = 0; E_md_div = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        int exp_cnt;
        int busy_cycles;
        //            rs tu  rt tu  ewa etn mwa mtn md req exp
        vecs[0]  = mk(2, 1,  0, 3,  2, 2,  0, 0,  0, 0, 1); // load-use on rs
        vecs[1]  = mk(0, 0,  0, 3,  0, 2,  0, 0,  0, 0, 0); // $0 exempt
        vecs[2]  = mk(2, 3,  0, 3,  2, 3,  0, 0,  0, 0, 0); // tuse=3 unused
        vecs[3]  = mk(0, 3,  5, 0,  0, 0,  5, 1,  0, 0, 1); // rt vs M
        vecs[4]  = mk(0, 3,  5, 1,  0, 0,  5, 1,  0, 0, 0); // tnew==tuse ok
        vecs[5]  = mk(7, 0,  0, 3,  8, 2,  0, 0,  0, 0, 0); // address mismatch
        vecs[6]  = mk(2, 0,  0, 3,  2, 1,  0, 0,  0, 1, 0); // Req overrides
        vecs[7]  = mk(0, 3,  0, 3,  0, 0,  0, 0,  1, 0, 0); // md idle
        vecs[8]  = mk(31, 2, 0, 3, 31, 3,  0, 0,  0, 0, 1); // reg 31, tnew 3
        vecs[9]  = mk(0, 3,  0, 0,  0, 0,  0, 3,  0, 0, 0); // rt=$0 vs M_wa=0
        vecs[10] = mk(4, 2,  4, 0,  9, 3,  4, 1,  0, 0, 1); // rt hits M, rs safe
        vecs[11] = mk(4, 2,  0, 3,  4, 2,  4, 2,  0, 0, 0); // both equal tuse

        set_idle();
        reset = 1;
        D_rs_addr = 2; D_rs_tuse = 1; E_wa = 2; E_tnew = 2; D_is_md = 1; E_md_start = 1;
        #1;
        chk_ctrl("reset_forced", 1'b0);
        @(negedge clk);
        chk("reset.stall_cnt", stall_cnt, 32'd0);
        chk("reset.md_busy", {31'd0, md_busy}, 32'd0);
        do_reset();

        // Hazard table: each vector spans exactly one clock edge
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #1;
            chk_ctrl($sformatf("vec%0d", i), vecs[i].exp_stall);
            if (vecs[i].exp_stall) exp_cnt++;
            @(negedge clk);
        end
        chk("table.stall_cnt", stall_cnt, 32'(exp_cnt));

        // lw followed by dependent add
        do_reset();
        D_rs_addr = 2; D_rs_tuse = 1; E_wa = 2; E_tnew = 2;
        #1 chk_ctrl("lw_use.c0", 1'b1);
        @(negedge clk);
        E_wa = 0; E_tnew = 0; M_wa = 2; M_tnew = 1;
        #1 chk_ctrl("lw_use.c1", 1'b0);
        @(negedge clk);
        chk("lw_use.stall_cnt", stall_cnt, 32'd1);

        // Multiply occupies the MDU for five cycles
        do_reset();
        E_md_start = 1; E_md_div = 0; D_is_md = 1;
        #1;
        chk("mult.t0.busy", {31'd0, md_busy}, 32'd0);
        chk("mult.t0.stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        E_md_start = 0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("mult.t%0d.busy", k), {31'd0, md_busy}, 32'd1);
            chk($sformatf("mult.t%0d.stall", k), {31'd0, stall}, 32'd1);
            @(negedge clk);
        end
        #1;
        chk("mult.t6.busy", {31'd0, md_busy}, 32'd0);
        chk("mult.t6.stall", {31'd0, stall}, 32'd0);
        chk("mult.stall_cnt", stall_cnt, 32'd6);

        // A start flushed by Req is not accepted
        do_reset();
        E_md_start = 1; E_md_div = 1; Req = 1; D_is_md = 1;
        #1 chk_ctrl("req_start", 1'b0);
        @(negedge clk);
        set_idle();
        #1 chk("req_start.busy", {31'd0, md_busy}, 32'd0);

        // Divide keeps counting through a flush; total busy stays at ten cycles
        @(negedge clk);
        E_md_start = 1; E_md_div = 1;
        @(negedge clk);
        E_md_start = 0; Req = 1; D_is_md = 1;
        #1;
        chk_ctrl("div_req", 1'b0);
        chk("div_req.busy", {31'd0, md_busy}, 32'd1);
        @(negedge clk);
        Req = 0;
        #1 chk_ctrl("div_after_req", 1'b1);
        busy_cycles = 1;
        while (md_busy && busy_cycles < 20) begin
            busy_cycles++;
            @(negedge clk);
            #1;
        end
        chk("div.busy_cycles", 32'(busy_cycles), 32'd10);

        // Reset in the middle of a divide
        do_reset();
        E_md_start = 1; E_md_div = 1;
        @(negedge clk);
        E_md_start = 0; D_is_md = 1;
        repeat (3) @(negedge clk);
        reset = 1;
        #1;
        chk("mid_reset.busy_before", {31'd0, md_busy}, 32'd1);
        chk_ctrl("mid_reset.forced", 1'b0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("mid_reset.busy", {31'd0, md_busy}, 32'd0);
        chk("mid_reset.stall", {31'd0, stall}, 32'd0);
        chk("mid_reset.stall_cnt", stall_cnt, 32'd0);

        // Saturation: preload near the top and hold a stall
        do_reset();
        D_is_md = 1; E_md_start = 1;
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt;
        @(negedge clk);
        E_md_start = 0;
        chk("sat.c1", stall_cnt, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("sat.c2", stall_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("sat.hold", stall_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("sat.hold2", stall_cnt, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
